tx_port_scheduler: RTL and testbench
====================================

// Module: tx_port_scheduler
// PURPOSE
//   Sequences transmit mode for the two Ethernet ports (tx_port_0/tx_port_1).
//   Arbitrates transmit requests round-robin and grants one port at a time a bounded slot.
//   Drives each port's mode: 2'b01 = idle, 2'b10 = transmit.
//   Inserts a guard gap between slots; replaces the single-port start-button mode FSM.
// PARAMETERS
//   CNT_W     32    slot/gap counter width
//   SLOT_LEN  1000  max transmit slot length in clk cycles (1..2^CNT_W-1)
//   GAP_LEN   16    guard cycles between slots (0 treated as 1)
// PORTS
//   clk        in   1      200 MHz system clock; single clock domain
//   reset      in   1      synchronous, active-high reset
//   enable     in   1      1 = scheduling allowed; 0 = no new grants
//   req_0      in   1      port 0 transmit request, level
//   req_1      in   1      port 1 transmit request, level
//   done_0     in   1      port 0 frame complete, 1-cycle pulse
//   done_1     in   1      port 1 frame complete, 1-cycle pulse
//   mode_0     out  2      port 0 TX mode (01 idle, 10 transmit)
//   mode_1     out  2      port 1 TX mode (01 idle, 10 transmit)
//   grant_0    out  1      1 while port 0 owns the slot
//   grant_1    out  1      1 while port 1 owns the slot
//   timeout_0  out  1      1-cycle pulse: port 0 slot ended by SLOT_LEN
//   timeout_1  out  1      1-cycle pulse: port 1 slot ended by SLOT_LEN
//   busy       out  1      1 whenever state != IDLE
// BEHAVIOUR
//   Reset (sync, next edge, from any state):
//     state=IDLE; mode_0=mode_1=01; grants=0; timeouts=0; busy=0; cnt=0; last=1 (port 0 wins first).
//   All outputs are registered.
//   States:
//     IDLE -> TX0/TX1 -> GAP -> IDLE
//   IDLE:
//     - Advances when enable && (req_0 || req_1) is sampled at edge N.
//     - Single request: that port is granted.
//     - Both requests: the port != last is granted.
//     - From edge N+1: mode_n=10, grant_n=1, cnt=0.
//   TXn:
//     - cnt increments every cycle.
//     - Exits on done_n, or on cnt==SLOT_LEN-1 (timeout).
//     - On exit edge: mode_n=01, grant_n=0, last=n, cnt=0, state=GAP.
//     - Timeout exit: timeout_n=1 for exactly that one cycle.
//     - done_n and timeout in the same cycle: treated as done; no timeout pulse.
//     - done of the non-granted port: ignored.
//     - enable or req_n deasserted mid-slot: no abort; slot runs to done/timeout.
//     - mode_n=10 lasts at most SLOT_LEN cycles.
//   GAP:
//     - mode_0=mode_1=01 for max(GAP_LEN,1) cycles, then IDLE.
//     - Requests are not sampled during GAP.
//   Invariants:
//     - Never both mode_x=10; never both grants=1.
//     - grant_n==1 iff mode_n==10.
//   Request withdrawn before grant: not granted; no latched pending state.
//   Counter: CNT_W-bit unsigned, cleared on every state entry; never wraps (SLOT_LEN < 2^CNT_W).
// TESTING (SLOT_LEN=8, GAP_LEN=4 unless noted)
//   1. Reset held 3 cycles, reqs high -> mode_0=mode_1=01, grants=0, busy=0, timeouts=0.
//   2. req_0 only at edge N; done_0 at N+5
//      -> mode_0=10 for edges N+1..N+5, then 01; 4 gap cycles; busy=0 at N+10.
//   3. req_0=req_1=1 held, done 3 cycles into each slot
//      -> grant order 0,1,0,1; mode_x never both 10.
//   4. req_1 only, no done -> mode_1=10 exactly 8 cycles; timeout_1 one-cycle pulse on exit; timeout_0=0.
//   5. reset pulsed mid TX0 -> next edge all outputs at reset values;
//      release with both reqs -> port 0 granted first.
//   6. enable=0 with reqs -> stays IDLE, busy=0.
//      done_1 on the same cycle as the SLOT_LEN boundary -> exit with timeout_1=0.

Source files
------------

// File: rtl/tx_port_scheduler_if.sv
// Control/status bundle between the two-port TX scheduler and its port logic.
// The scheduler takes the slave side; whoever raises requests takes the master side.
interface tx_port_scheduler_if;
   logic       enable;
   logic       req_0;
   logic       req_1;
   logic       done_0;
   logic       done_1;
   logic [1:0] mode_0;
   logic [1:0] mode_1;
   logic       grant_0;
   logic       grant_1;
   logic       timeout_0;
   logic       timeout_1;
   logic       busy;

   modport master (
      output enable, req_0, req_1, done_0, done_1,
      input  mode_0, mode_1, grant_0, grant_1, timeout_0, timeout_1, busy
   );

   modport slave (
      input  enable, req_0, req_1, done_0, done_1,
      output mode_0, mode_1, grant_0, grant_1, timeout_0, timeout_1, busy
   );
endinterface

// File: rtl/tx_port_scheduler.sv
// Round-robin transmit scheduler for two Ethernet ports: one bounded TX slot at a
// time, a guard gap after every slot, and fully registered mode/grant/status outputs.
module tx_port_scheduler #(
   parameter int CNT_W    = 32,
   parameter int SLOT_LEN = 1000,
   parameter int GAP_LEN  = 16
) (
   input  logic              clk,
   input  logic              reset,
   tx_port_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TX0  = 2'd1,
      S_TX1  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [1:0]       MODE_IDLE = 2'b01;
   localparam logic [1:0]       MODE_TX   = 2'b10;
   localparam int               GAP_EFF   = (GAP_LEN < 1) ? 1 : GAP_LEN;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_last;
   logic             w_last_nxt;
   logic             w_timeout_0_nxt;
   logic             w_timeout_1_nxt;

   logic [1:0]       r_mode_0;
   logic [1:0]       r_mode_1;
   logic             r_grant_0;
   logic             r_grant_1;
   logic             r_timeout_0;
   logic             r_timeout_1;
   logic             r_busy;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_last_nxt      = r_last;
      w_timeout_0_nxt = 1'b0;
      w_timeout_1_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.enable && (bus.req_0 || bus.req_1)) begin
               // On contention the port that did not own the previous slot wins.
               if (bus.req_0 && bus.req_1) begin
                  w_state_nxt = r_last ? S_TX0 : S_TX1;
               end else begin
                  w_state_nxt = bus.req_0 ? S_TX0 : S_TX1;
               end
               w_cnt_nxt = '0;
            end
         end

         S_TX0: begin
            if (bus.done_0 || (r_cnt == SLOT_LAST)) begin
               w_state_nxt     = S_GAP;
               w_cnt_nxt       = '0;
               w_last_nxt      = 1'b0;
               w_timeout_0_nxt = ~bus.done_0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         S_TX1: begin
            if (bus.done_1 || (r_cnt == SLOT_LAST)) begin
               w_state_nxt     = S_GAP;
               w_cnt_nxt       = '0;
               w_last_nxt      = 1'b1;
               w_timeout_1_nxt = ~bus.done_1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_mode_0    <= MODE_IDLE;
         r_mode_1    <= MODE_IDLE;
         r_grant_0   <= 1'b0;
         r_grant_1   <= 1'b0;
         r_timeout_0 <= 1'b0;
         r_timeout_1 <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_mode_0    <= (w_state_nxt == S_TX0) ? MODE_TX : MODE_IDLE;
         r_mode_1    <= (w_state_nxt == S_TX1) ? MODE_TX : MODE_IDLE;
         r_grant_0   <= (w_state_nxt == S_TX0);
         r_grant_1   <= (w_state_nxt == S_TX1);
         r_timeout_0 <= w_timeout_0_nxt;
         r_timeout_1 <= w_timeout_1_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(r_grant_0 && r_grant_1));
         assert (r_grant_0 == (r_mode_0 == MODE_TX));
         assert (r_grant_1 == (r_mode_1 == MODE_TX));
      end
   end

   assign bus.mode_0    = r_mode_0;
   assign bus.mode_1    = r_mode_1;
   assign bus.grant_0   = r_grant_0;
   assign bus.grant_1   = r_grant_1;
   assign bus.timeout_0 = r_timeout_0;
   assign bus.timeout_1 = r_timeout_1;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_tx_port_scheduler.sv
// Directed bench for tx_port_scheduler with SLOT_LEN=8, GAP_LEN=4; expected output
// vectors are written out by hand for each step of the sequence.
module tb_tx_port_scheduler;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   tx_port_scheduler_if bus ();

   tx_port_scheduler #(
      .CNT_W    (32),
      .SLOT_LEN (8),
      .GAP_LEN  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=time-limit expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Expected packed vector {mode_0, mode_1, grant_0, grant_1, timeout_0, timeout_1, busy}.
   function automatic logic [8:0] ev(input bit g0, input bit g1, input bit t0,
                                     input bit t1, input bit b);
      logic [1:0] m0;
      logic [1:0] m1;
      m0 = g0 ? 2'b10 : 2'b01;
      m1 = g1 ? 2'b10 : 2'b01;
      return {m0, m1, g0, g1, t0, t1, b};
   endfunction

   function automatic logic [8:0] obs();
      return {bus.mode_0, bus.mode_1, bus.grant_0, bus.grant_1,
              bus.timeout_0, bus.timeout_1, bus.busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] e);
      logic [8:0] o;
      o = obs();
      n_chk++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // Pulse done for port p, then walk the 4-cycle gap back to idle.
   task automatic finish_slot(input int p, input string tag);
      bus.done_0 = (p == 0);
      bus.done_1 = (p == 1);
      tick();
      bus.done_0 = 1'b0;
      bus.done_1 = 1'b0;
      chk({tag, "_gap"}, ev(0, 0, 0, 0, 1));
      repeat (4) tick();
      chk({tag, "_idle"}, ev(0, 0, 0, 0, 0));
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      reset      = 1'b1;
      bus.enable = 1'b1;
      bus.req_0  = 1'b1;
      bus.req_1  = 1'b1;
      bus.done_0 = 1'b0;
      bus.done_1 = 1'b0;

      // 1: reset held with both requests high
      repeat (3) tick();
      chk("t1_reset", ev(0, 0, 0, 0, 0));

      // 2: port 0 alone, done after 5 granted cycles, 4 gap cycles
      reset     = 1'b0;
      bus.req_1 = 1'b0;
      tick();
      chk("t2_grant", ev(1, 0, 0, 0, 1));
      bus.req_0 = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk("t2_slot", ev(1, 0, 0, 0, 1));
      end
      bus.done_0 = 1'b1;
      tick();
      bus.done_0 = 1'b0;
      chk("t2_exit", ev(0, 0, 0, 0, 1));
      for (int k = 7; k <= 9; k++) begin
         tick();
         chk("t2_gap", ev(0, 0, 0, 0, 1));
      end
      tick();
      chk("t2_idle", ev(0, 0, 0, 0, 0));

      // 3: both requests held from reset -> grant order 0,1,0,1
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      bus.req_0 = 1'b1;
      bus.req_1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_grant", ev(i % 2 == 0, i % 2 == 1, 0, 0, 1));
         bus.done_0 = (i % 2 == 1);
         bus.done_1 = (i % 2 == 0);
         tick();
         bus.done_0 = 1'b0;
         bus.done_1 = 1'b0;
         chk("t3_other_done", ev(i % 2 == 0, i % 2 == 1, 0, 0, 1));
         tick();
         chk("t3_slot", ev(i % 2 == 0, i % 2 == 1, 0, 0, 1));
         if (i == 3) begin
            bus.req_0 = 1'b0;
            bus.req_1 = 1'b0;
         end
         finish_slot(i % 2, "t3");
      end

      // 4: port 1 alone, no done -> 8-cycle slot ending in a timeout pulse
      bus.req_1 = 1'b1;
      tick();
      chk("t4_grant", ev(0, 1, 0, 0, 1));
      bus.req_1 = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         chk("t4_slot", ev(0, 1, 0, 0, 1));
      end
      tick();
      chk("t4_timeout", ev(0, 0, 0, 1, 1));
      tick();
      chk("t4_pulse_end", ev(0, 0, 0, 0, 1));
      repeat (3) tick();
      chk("t4_idle", ev(0, 0, 0, 0, 0));

      // 5: make port 0 the last owner, then reset in the middle of a port 0 slot
      bus.req_0 = 1'b1;
      tick();
      chk("t5_pre_grant", ev(1, 0, 0, 0, 1));
      bus.req_0 = 1'b0;
      finish_slot(0, "t5_pre");
      bus.req_0 = 1'b1;
      tick();
      chk("t5_grant", ev(1, 0, 0, 0, 1));
      tick();
      reset     = 1'b1;
      bus.req_1 = 1'b1;
      tick();
      chk("t5_reset", ev(0, 0, 0, 0, 0));
      reset = 1'b0;
      tick();
      chk("t5_first", ev(1, 0, 0, 0, 1));
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
      finish_slot(0, "t5");

      // 6: enable low blocks grants; done_1 on the slot boundary suppresses timeout
      bus.enable = 1'b0;
      bus.req_0  = 1'b1;
      bus.req_1  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_disabled", ev(0, 0, 0, 0, 0));
      end
      bus.enable = 1'b1;
      bus.req_0  = 1'b0;
      tick();
      chk("t6_grant", ev(0, 1, 0, 0, 1));
      bus.req_1 = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         chk("t6_slot", ev(0, 1, 0, 0, 1));
      end
      bus.done_1 = 1'b1;
      tick();
      bus.done_1 = 1'b0;
      chk("t6_done_wins", ev(0, 0, 0, 0, 1));
      repeat (4) tick();
      chk("t6_idle", ev(0, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
